// File: rtl/decode_pkg.sv
// Shared opcode, writeback-select and state definitions for the decode sequencer.
// Opcodes are the top five bits of the instruction word.
package decode_pkg;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_CALL = 5'b00001;
  localparam logic [4:0] OP_CMPR = 5'b00010;
  localparam logic [4:0] OP_CMPI = 5'b00011;
  localparam logic [4:0] OP_JMPR = 5'b00100;
  localparam logic [4:0] OP_JMPI = 5'b00101;
  localparam logic [4:0] OP_RTN  = 5'b11100;
  localparam logic [4:0] OP_STP  = 5'b11111;

  // ALU-style families: base pattern plus a mask of the bits that must match
  localparam logic [4:0] OP_ADD  = 5'b01000;
  localparam logic [4:0] OP_SUB  = 5'b01010;
  localparam logic [4:0] OP_MAS  = 5'b01100;
  localparam logic [4:0] OP_MOV  = 5'b01110;
  localparam logic [4:0] OP_LSX  = 5'b11000;
  localparam logic [4:0] OPM_PAIR = 5'b11110;
  localparam logic [4:0] OPM_LSX  = 5'b11101;

  localparam logic [2:0] GM_ALU = 3'b100;
  localparam logic [2:0] GM_MAS = 3'b101;
  localparam logic [2:0] GM_RS  = 3'b000;
  localparam logic [2:0] GM_N   = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    CL_NOP,
    CL_CALL,
    CL_CMPR,
    CL_CMPI,
    CL_JMPR,
    CL_JMPI,
    CL_RTN,
    CL_ALU,
    CL_MAS,
    CL_MOV,
    CL_HALT
  } op_class_e;

  function automatic op_class_e classify(input logic [4:0] op);
    op_class_e cls;
    cls = CL_HALT;
    if (((op & OPM_PAIR) == OP_ADD) || ((op & OPM_PAIR) == OP_SUB) ||
        ((op & OPM_LSX) == OP_LSX)) begin
      cls = CL_ALU;
    end else if ((op & OPM_PAIR) == OP_MAS) begin
      cls = CL_MAS;
    end else if ((op & OPM_PAIR) == OP_MOV) begin
      cls = CL_MOV;
    end else begin
      case (op)
        OP_NOP:  cls = CL_NOP;
        OP_CALL: cls = CL_CALL;
        OP_CMPR: cls = CL_CMPR;
        OP_CMPI: cls = CL_CMPI;
        OP_JMPR: cls = CL_JMPR;
        OP_JMPI: cls = CL_JMPI;
        OP_RTN:  cls = CL_RTN;
        OP_STP:  cls = CL_HALT;
        default: cls = CL_HALT;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/decode_sequencer_return_stack.sv
// Hardware return stack for CALL/RTN: pointer-based LIFO with full/empty flags.
// Push on full and pop on empty are ignored here; the sequencer records them.
module return_stack
  import decode_pkg::*;
#(
  parameter int DW       = 16,
  parameter int RS_DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] push_data,
  output logic [DW-1:0] top,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(RS_DEPTH);

  logic [AW:0]   r_cnt;
  logic [DW-1:0] r_mem [RS_DEPTH];
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_top_idx;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_wr_idx  = r_cnt[AW-1:0];
  assign w_top_idx = w_wr_idx - AW'(1);
  assign full      = (r_cnt == (AW+1)'(RS_DEPTH));
  assign empty     = (r_cnt == '0);
  assign top       = r_mem[w_top_idx];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_do_push) begin
      r_cnt <= r_cnt + (AW+1)'(1);
    end else if (w_do_pop) begin
      r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

  // Storage is not reset: an empty pointer makes old contents unreachable
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/decode_sequencer.sv
// Fetch/execute sequencer: owns the PC, decodes each fetched word in a single
// EXEC cycle, drives datapath strobes and manages the internal return stack.
module decode_sequencer
  import decode_pkg::*;
#(
  parameter int              DW       = 16,
  parameter int              RS_DEPTH = 8,
  parameter int              SKW      = 2,
  parameter logic [DW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] instr,
  input  logic [DW-1:0] N,
  input  logic          instr_valid,
  input  logic          jump_cond,
  input  logic [DW-1:0] rddata,
  input  logic          resume,
  output logic          fetch_req,
  output logic [DW-1:0] fetch_addr,
  output logic [DW-1:0] pc,
  output logic          rd_wen,
  output logic [2:0]    giantmux_sel,
  output logic          halted,
  output logic          rs_overflow,
  output logic          rs_underflow
);

  state_e        r_state;
  state_e        w_next_state;
  logic [DW-1:0] r_pc;
  logic [DW-1:0] r_ir;
  logic [DW-1:0] r_nr;
  logic          r_ovf;
  logic          r_unf;

  logic [DW-1:0] w_next_pc;
  logic          w_push;
  logic          w_pop;
  logic          w_set_ovf;
  logic          w_set_unf;
  logic          w_rd_wen;
  logic [2:0]    w_gm_sel;

  logic [4:0]    w_op;
  op_class_e     w_cls;
  logic          w_imm;
  logic [DW-1:0] w_skip;
  logic [DW-1:0] w_pc1;
  logic [DW-1:0] w_pc2;
  logic [DW-1:0] w_pc_len;
  logic [DW-1:0] w_rs_top;
  logic          w_rs_full;
  logic          w_rs_empty;
  logic          w_unused_ir;

  // Two-word ALU forms are flagged by bit 11 of the instruction
  assign w_op        = r_ir[DW-1:DW-5];
  assign w_cls       = classify(w_op);
  assign w_imm       = r_ir[11];
  assign w_skip      = {{(DW-SKW){1'b0}}, r_ir[SKW-1:0]} + DW'(1);
  assign w_pc1       = r_pc + DW'(1);
  assign w_pc2       = r_pc + DW'(2);
  assign w_pc_len    = w_imm ? w_pc2 : w_pc1;
  assign w_unused_ir = ^r_ir;

  return_stack #(
    .DW       (DW),
    .RS_DEPTH (RS_DEPTH)
  ) u_rs (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc2),
    .top       (w_rs_top),
    .full      (w_rs_full),
    .empty     (w_rs_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_nr    <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      if (r_state == ST_FETCH && instr_valid) begin
        r_ir <= instr;
        r_nr <= N;
      end
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_unf) r_unf <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_set_ovf    = 1'b0;
    w_set_unf    = 1'b0;
    w_rd_wen     = 1'b0;
    w_gm_sel     = GM_RS;
    case (r_state)
      ST_IDLE: w_next_state = ST_FETCH;
      ST_FETCH: begin
        if (instr_valid) w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        w_next_state = ST_FETCH;
        case (w_cls)
          CL_NOP:  w_next_pc = w_pc1;
          CL_JMPR: w_next_pc = rddata;
          CL_JMPI: w_next_pc = r_nr;
          CL_CMPR: w_next_pc = jump_cond ? (w_pc1 + w_skip) : w_pc1;
          CL_CMPI: w_next_pc = jump_cond ? (w_pc2 + w_skip) : w_pc2;
          CL_CALL: begin
            // A full stack drops the return address but still takes the jump
            w_next_pc = r_nr;
            if (w_rs_full) w_set_ovf = 1'b1;
            else           w_push    = 1'b1;
          end
          CL_RTN: begin
            if (w_rs_empty) begin
              w_set_unf    = 1'b1;
              w_next_state = ST_HALT;
            end else begin
              w_pop     = 1'b1;
              w_next_pc = w_rs_top;
            end
          end
          CL_ALU: begin
            w_rd_wen  = 1'b1;
            w_gm_sel  = GM_ALU;
            w_next_pc = w_pc_len;
          end
          CL_MAS: begin
            w_rd_wen  = 1'b1;
            w_gm_sel  = GM_MAS;
            w_next_pc = w_pc_len;
          end
          CL_MOV: begin
            w_rd_wen  = 1'b1;
            w_gm_sel  = w_imm ? GM_N : GM_RS;
            w_next_pc = w_pc_len;
          end
          default: w_next_state = ST_HALT;
        endcase
      end
      ST_HALT: begin
        if (resume) begin
          w_next_pc    = w_pc1;
          w_next_state = ST_FETCH;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign fetch_req    = (r_state == ST_FETCH);
  assign fetch_addr   = r_pc;
  assign pc           = r_pc;
  assign rd_wen       = w_rd_wen;
  assign giantmux_sel = w_gm_sel;
  assign halted       = (r_state == ST_HALT);
  assign rs_overflow  = r_ovf;
  assign rs_underflow = r_unf;

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer: a small instruction memory feeds the
// sequencer, and per-instruction expectations flow through a scoreboard queue.
module tb_decode_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic [15:0] N;
  logic        instr_valid;
  logic        jump_cond;
  logic [15:0] rddata;
  logic        resume;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic [15:0] pc;
  logic        rd_wen;
  logic [2:0]  giantmux_sel;
  logic        halted;
  logic        rs_overflow;
  logic        rs_underflow;

  logic [15:0] mem [0:65535];
  logic [15:0] naddr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic        wen;
    logic [2:0]  sel;
    logic        halt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb_q[$];

  decode_sequencer #(
    .DW       (16),
    .RS_DEPTH (8),
    .SKW      (2),
    .RESET_PC (16'h0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .N            (N),
    .instr_valid  (instr_valid),
    .jump_cond    (jump_cond),
    .rddata       (rddata),
    .resume       (resume),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .pc           (pc),
    .rd_wen       (rd_wen),
    .giantmux_sel (giantmux_sel),
    .halted       (halted),
    .rs_overflow  (rs_overflow),
    .rs_underflow (rs_underflow)
  );

  always #5 clk = ~clk;

  assign naddr = fetch_addr + 16'd1;
  assign instr = mem[fetch_addr];
  assign N     = mem[naddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge while the DUT sits in FETCH with instr_valid high
  task automatic step(input string tag, input logic [15:0] epc, input logic ewen,
                      input logic [2:0] esel, input logic ehalt, input logic eovf,
                      input logic eunf);
    exp_t e;
    sb_q.push_back({epc, ewen, esel, ehalt, eovf, eunf});
    chk({tag, ".fetch_req"}, {31'd0, fetch_req}, 32'd1);
    chk({tag, ".fetch_wen"}, {31'd0, rd_wen}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    chk({tag, ".exec_req"}, {31'd0, fetch_req}, 32'd0);
    chk({tag, ".rd_wen"}, {31'd0, rd_wen}, {31'd0, e.wen});
    chk({tag, ".gm_sel"}, {29'd0, giantmux_sel}, {29'd0, e.sel});
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".pc"}, {16'd0, pc}, {16'd0, e.pc});
    chk({tag, ".fetch_addr"}, {16'd0, fetch_addr}, {16'd0, e.pc});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e.halt});
    chk({tag, ".ovf"}, {31'd0, rs_overflow}, {31'd0, e.ovf});
    chk({tag, ".unf"}, {31'd0, rs_underflow}, {31'd0, e.unf});
    chk({tag, ".post_req"}, {31'd0, fetch_req}, {31'd0, !e.halt});
    chk({tag, ".post_wen"}, {31'd0, rd_wen}, 32'd0);
  endtask

  task automatic do_resume(input string tag, input logic [15:0] epc);
    resume = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resume = 1'b0;
    chk({tag, ".pc"}, {16'd0, pc}, {16'd0, epc});
    chk({tag, ".halted"}, {31'd0, halted}, 32'd0);
    chk({tag, ".fetch_req"}, {31'd0, fetch_req}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    jump_cond = 1'b0;
    rddata = '0;
    resume = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;

    mem[16'h0001] = 16'h2800; mem[16'h0002] = 16'h0005;
    mem[16'h0005] = 16'h4800; mem[16'h0006] = 16'h1234;
    mem[16'h0007] = 16'h7000;
    mem[16'h0008] = 16'h7800; mem[16'h0009] = 16'hBEEF;
    mem[16'h000A] = 16'h6000;
    mem[16'h000B] = 16'hC000;
    mem[16'h000C] = 16'hD000;
    mem[16'h000D] = 16'h5000;
    mem[16'h000E] = 16'h2000;
    mem[16'h0010] = 16'h0800; mem[16'h0011] = 16'h0040;
    mem[16'h0040] = 16'hE000;
    mem[16'h0012] = 16'h2800; mem[16'h0013] = 16'h0020;
    mem[16'h0020] = 16'h1803;
    mem[16'h0026] = 16'h2800; mem[16'h0027] = 16'h0020;
    mem[16'h0022] = 16'h1000;
    mem[16'h0024] = 16'h1003;
    mem[16'h0025] = 16'h2000;
    for (int k = 0; k < 9; k++) begin
      mem[16'h0100 + 16'(k * 16)] = 16'h0800;
      mem[16'h0101 + 16'(k * 16)] = 16'h0110 + 16'(k * 16);
    end
    mem[16'h0190] = 16'hE000;
    for (int k = 0; k < 8; k++) mem[16'h0112 + 16'(k * 16)] = 16'hE000;
    mem[16'h0102] = 16'hE000;
    mem[16'h0103] = 16'h8000;
    mem[16'h0104] = 16'h2800; mem[16'h0105] = 16'hFFFF;
    mem[16'hFFFF] = 16'hF800;

    #12;
    chk("rst.pc", {16'd0, pc}, 32'h0);
    chk("rst.fetch_addr", {16'd0, fetch_addr}, 32'h0);
    chk("rst.fetch_req", {31'd0, fetch_req}, 32'd0);
    chk("rst.rd_wen", {31'd0, rd_wen}, 32'd0);
    chk("rst.gm_sel", {29'd0, giantmux_sel}, 32'd0);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    chk("rst.ovf", {31'd0, rs_overflow}, 32'd0);
    chk("rst.unf", {31'd0, rs_underflow}, 32'd0);

    @(negedge clk);
    reset = 1'b0;
    instr_valid = 1'b1;
    chk("idle.fetch_req", {31'd0, fetch_req}, 32'd0);
    @(posedge clk);
    @(negedge clk);

    step("nop",     16'h0001, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    step("jmpi5",   16'h0005, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    resume = 1'b1;
    step("addi",    16'h0007, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
    resume = 1'b0;
    step("movr",    16'h0008, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    step("movi",    16'h000A, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    step("mas",     16'h000B, 1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
    step("lsl",     16'h000C, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
    step("lsr",     16'h000D, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
    step("sub",     16'h000E, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
    rddata = 16'h0010;
    step("jmpr",    16'h0010, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    rddata = 16'h0000;
    step("call",    16'h0040, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    step("rtn",     16'h0012, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    step("jmpi20",  16'h0020, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    jump_cond = 1'b1;
    step("cmpi_t",  16'h0026, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    step("jmpi20b", 16'h0020, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    jump_cond = 1'b0;
    step("cmpi_n",  16'h0022, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    jump_cond = 1'b1;
    step("cmpr_t",  16'h0024, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    jump_cond = 1'b0;
    step("cmpr_n",  16'h0025, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    rddata = 16'h0100;
    step("jmpr100", 16'h0100, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 9; k++) begin
      step($sformatf("call%0d", k), 16'h0110 + 16'(k * 16), 1'b0, 3'b000, 1'b0,
           (k == 8), 1'b0);
    end
    for (int j = 0; j < 8; j++) begin
      step($sformatf("pop%0d", j), 16'h0172 - 16'(j * 16), 1'b0, 3'b000, 1'b0,
           1'b1, 1'b0);
    end
    step("rtn_empty", 16'h0102, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1);

    @(posedge clk);
    @(negedge clk);
    chk("halt_hold.pc", {16'd0, pc}, 32'h0102);
    chk("halt_hold.halted", {31'd0, halted}, 32'd1);
    do_resume("resume1", 16'h0103);

    step("undef",   16'h0103, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1);
    do_resume("resume2", 16'h0104);
    step("jmpiff",  16'hFFFF, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1);
    step("stp",     16'hFFFF, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1);
    do_resume("wrap", 16'h0000);
    chk("wrap.fetch_addr", {16'd0, fetch_addr}, 32'h0);
    step("nop2",    16'h0001, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1);

    instr_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("wait.fetch_req", {31'd0, fetch_req}, 32'd1);
      chk("wait.pc", {16'd0, pc}, 32'h0001);
    end

    #2 reset = 1'b1;
    #1;
    chk("arst.pc", {16'd0, pc}, 32'h0);
    chk("arst.fetch_req", {31'd0, fetch_req}, 32'd0);
    chk("arst.halted", {31'd0, halted}, 32'd0);
    chk("arst.ovf", {31'd0, rs_overflow}, 32'd0);
    chk("arst.unf", {31'd0, rs_underflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step("nop3",    16'h0001, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_sequencer.md
Name: decode_sequencer

Overview:
- Parametrised, sequential successor to the combinational instruction decoder.
- Owns the PC, a fetch/execute state machine with a memory-ready handshake, and an internal hardware return stack for CALL/RTN.
- Emits per-instruction control strobes to the datapath.
- Sits between instruction memory and the register file/ALU/giant mux; replaces the external PC counter plus load logic.

Parameters:
DW, 16, data/address width; opcode is instr[DW-1:DW-5]; DW >= 16
RS_DEPTH, 8, return-stack entries (power of two, >= 2)
SKW, 2, width of CMP skip field instr[SKW-1:0]
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
instr  in  DW  instruction word at fetch_addr
N  in  DW  immediate word at fetch_addr+1
instr_valid  in  1  instr and N valid this cycle (fetch handshake ack)
jump_cond  in  1  comparator result, sampled in EXEC
rddata  in  DW  Rd register value, sampled in EXEC
resume  in  1  leaves HALT
fetch_req  out  1  fetch request
fetch_addr  out  DW  equals pc
pc  out  DW  current instruction address (registered)
rd_wen  out  1  register write enable, one EXEC cycle
giantmux_sel  out  3  writeback source select
halted  out  1  high in HALT
rs_overflow  out  1  sticky: push attempted when stack full
rs_underflow  out  1  sticky: pop attempted when stack empty

Behaviour:
- Reset: async reset, active high.
  - state=IDLE, pc=RESET_PC, stack empty, IR/NR=0, both sticky flags cleared.
  - All outputs 0, except fetch_addr=RESET_PC.
  - Reset asserted mid-fetch or mid-EXEC aborts immediately; no PC or stack update occurs.
- States: IDLE, FETCH, EXEC, HALT.
  - IDLE -> FETCH unconditionally on the first clock after reset.
  - FETCH: fetch_req=1. Hold while instr_valid=0. When instr_valid=1, capture IR<=instr and NR<=N, then go to EXEC.
  - EXEC: exactly one cycle. Decode IR, drive strobes combinationally, load next pc, then go to FETCH, or to HALT.
  - HALT: halted=1, fetch_req=0. When resume=1: pc<=pc+1, go to FETCH.
- Instruction length: len=2 for CALL, JMP I, CMP I, and for ALU classes with IR[11]=1. Otherwise len=1.
- ALU classes: rd_wen=1, pc<=pc+len. giantmux_sel by class:
  - ADD 0100x, SUB 0101x, LSL/LSR 110x0 -> 100
  - MAS 0110x -> 101
  - MOV 0111x with IR[11]=0 -> 000; with IR[11]=1 -> 010
- Control flow (skip = IR[SKW-1:0]+1, zero-extended):
  - NOP 00000: pc<=pc+1.
  - JMP R 00100: pc<=rddata.
  - JMP I 00101: pc<=NR.
  - CALL 00001: push pc+2, then pc<=NR. If the stack is full: set rs_overflow, do not push, stack contents unchanged, jump still taken.
  - RTN 11100: pop into pc. If the stack is empty: set rs_underflow, pc unchanged, go to HALT.
  - CMP R 00010: jump_cond=1 -> pc+1+skip; else pc+1.
  - CMP I 00011: jump_cond=1 -> pc+2+skip; else pc+2.
- STP 11111 and any undefined opcode: go to HALT, pc unchanged (stays on the offending word).
- Arithmetic: all PC arithmetic is modulo 2^DW; wrap from all-ones to 0 is legal and silent.
- rd_wen and giantmux_sel are 0 outside EXEC.
- Latency: 1 fetch cycle (best case, instr_valid already high) + 1 EXEC cycle = 2 cycles per instruction.
- resume outside HALT is ignored. The sticky flags clear only on reset.

Decomposition:
- Shared package decode_pkg holds:
  - 5-bit opcode localparams (NOP, CALL, CMPR, CMPI, JMPR, JMPI, RTN, STP, and the ADD/SUB/MAS/MOV/LSx patterns)
  - giantmux_sel encodings (ALU=100, MAS=101, RS=000, N=010)
  - state enum
- One sub-module: return_stack (parameters DW, RS_DEPTH).
  - Ports: push/pop/push_data, top, full, empty.
  - Synchronous LIFO, pointer-based; never asserted with push and pop in the same cycle.

Test Plan:
- Reset then instr_valid=1 with NOP at 0 -> pc 0->1 after 2 cycles; fetch_req=1 in FETCH only; rd_wen=0 throughout.
- ADD immediate (instr=0x4800) at pc=5 -> rd_wen=1 and giantmux_sel=100 for one cycle; pc=7.
- CALL N=0x0040 at pc=0x0010, then RTN at 0x0040 -> pc=0x0040, then pc=0x0012; stack empty afterwards.
- CMP I at pc=0x20 with IR[1:0]=2'b11: jump_cond=1 -> pc=0x26; jump_cond=0 -> pc=0x22.
- Nine nested CALLs with RS_DEPTH=8 -> rs_overflow=1 after the 9th; then RTN on an empty stack -> rs_underflow=1, halted=1, pc unchanged.
- STP at 0xFFFF, then resume=1 -> pc wraps to 0x0000 and fetch resumes. Reset asserted while in FETCH -> pc=RESET_PC and state=IDLE immediately.
